// File: rtl/register_file.sv
// Eight 32-bit registers (R1..R4 general, S1..S4 scratch) that share one input bus and one function select.
// Two combinational read ports drive the ALU operand buses.

module register_32 (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        E,
    input  logic [2:0]  FunSel,
    input  logic [31:0] I,
    output logic [31:0] Q
);

    logic [31:0] q_next;

    always_comb begin
        q_next = Q;
        case (FunSel)
            3'b000:  q_next = Q - 32'd1;
            3'b001:  q_next = Q + 32'd1;
            3'b010:  q_next = I;
            3'b011:  q_next = 32'd0;
            3'b100:  q_next = {24'd0, I[7:0]};
            3'b101:  q_next = {16'd0, I[15:0]};
            3'b110:  q_next = {Q[23:0], I[7:0]};
            default: q_next = {{16{I[15]}}, I[15:0]};
        endcase
    end

    // Reset wins over the enable and FunSel.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            Q <= 32'd0;
        end else if (E) begin
            Q <= q_next;
        end
    end

endmodule

module register_file (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] I,
    input  logic [2:0]  FunSel,
    input  logic [3:0]  RegSel,
    input  logic [3:0]  ScrSel,
    input  logic [2:0]  OutASel,
    input  logic [2:0]  OutBSel,
    output logic [31:0] OutA,
    output logic [31:0] OutB
);

    logic [7:0]  enable;
    logic [31:0] q [8];

    // Index 0..3 = R1..R4 and 4..7 = S1..S4, which matches the read-select encoding.
    // The MSB of each select nibble enables the first register of its group.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_enable
            assign enable[gi]     = RegSel[3-gi];
            assign enable[gi + 4] = ScrSel[3-gi];
        end
    endgenerate

    register_32 R1 (.Clock(Clock), .Reset(Reset), .E(enable[0]), .FunSel(FunSel), .I(I), .Q(q[0]));
    register_32 R2 (.Clock(Clock), .Reset(Reset), .E(enable[1]), .FunSel(FunSel), .I(I), .Q(q[1]));
    register_32 R3 (.Clock(Clock), .Reset(Reset), .E(enable[2]), .FunSel(FunSel), .I(I), .Q(q[2]));
    register_32 R4 (.Clock(Clock), .Reset(Reset), .E(enable[3]), .FunSel(FunSel), .I(I), .Q(q[3]));
    register_32 S1 (.Clock(Clock), .Reset(Reset), .E(enable[4]), .FunSel(FunSel), .I(I), .Q(q[4]));
    register_32 S2 (.Clock(Clock), .Reset(Reset), .E(enable[5]), .FunSel(FunSel), .I(I), .Q(q[5]));
    register_32 S3 (.Clock(Clock), .Reset(Reset), .E(enable[6]), .FunSel(FunSel), .I(I), .Q(q[6]));
    register_32 S4 (.Clock(Clock), .Reset(Reset), .E(enable[7]), .FunSel(FunSel), .I(I), .Q(q[7]));

    assign OutA = q[OutASel];
    assign OutB = q[OutBSel];

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes the expected read-port values, and a monitor pops and compares them.
// The reference model is an eight-word array that is updated from the arithmetic rules for each function.

module tb_register_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din;
    logic [2:0]  fun_sel;
    logic [3:0]  reg_sel;
    logic [3:0]  scr_sel;
    logic [2:0]  a_sel;
    logic [2:0]  b_sel;
    logic [31:0] out_a;
    logic [31:0] out_b;

    register_file dut (
        .Clock(clk), .Reset(rst_n), .I(din), .FunSel(fun_sel),
        .RegSel(reg_sel), .ScrSel(scr_sel), .OutASel(a_sel), .OutBSel(b_sel),
        .OutA(out_a), .OutB(out_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [2:0]  asel;
        logic [2:0]  bsel;
        logic [31:0] ea;
        logic [31:0] eb;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [8];
    bit          known = 1'b0;
    int          txn = 0;
    int          compared = 0;
    int          mismatched = 0;

    function automatic logic [31:0] apply(input logic [2:0] fs, input logic [31:0] q, input logic [31:0] i);
        case (fs)
            3'd0:    return q - 1;
            3'd1:    return q + 1;
            3'd2:    return i;
            3'd3:    return 0;
            3'd4:    return i & 32'h0000_00FF;
            3'd5:    return i & 32'h0000_FFFF;
            3'd6:    return (q << 8) | (i & 32'h0000_00FF);
            default: return 32'($signed(i[15:0]));
        endcase
    endfunction

    // One transaction per falling edge: drive inputs, record the pre-edge read values, then advance the model.
    task automatic op(input bit rn, input logic [2:0] fs, input logic [3:0] rs, input logic [3:0] ss,
                      input logic [31:0] i, input logic [2:0] as, input logic [2:0] bs);
        exp_t e;
        bit   en;
        @(negedge clk);
        rst_n = rn; fun_sel = fs; reg_sel = rs; scr_sel = ss; din = i; a_sel = as; b_sel = bs;
        txn++;
        if (known) begin
            e.id = txn; e.asel = as; e.bsel = bs; e.ea = model[as]; e.eb = model[bs];
            sb.push_back(e);
        end
        if (!rn) begin
            for (int k = 0; k < 8; k++) model[k] = 32'd0;
            known = 1'b1;
        end else begin
            for (int k = 0; k < 8; k++) begin
                en = (k < 4) ? rs[3-k] : ss[7-k];
                if (en) model[k] = apply(fs, model[k], i);
            end
        end
    endtask

    task automatic rd(input logic [2:0] as, input logic [2:0] bs);
        op(1'b1, 3'd0, 4'd0, 4'd0, 32'd0, as, bs);
    endtask

    task automatic read_all();
        for (int k = 0; k < 4; k++) rd(3'(k), 3'(k + 4));
    endtask

    task automatic load_all(input logic [31:0] v);
        op(1'b1, 3'd2, 4'hF, 4'hF, v, 3'd0, 3'd4);
    endtask

    // Monitor: samples the read ports mid low-phase, well away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                compared += 2;
                $display("txn %0d: OutA[%0d]=%08h (exp %08h) OutB[%0d]=%08h (exp %08h)",
                         e.id, e.asel, out_a, e.ea, e.bsel, out_b, e.eb);
                if (out_a !== e.ea) begin
                    mismatched++;
                    $display("FAIL outa txn %0d sel %0d: got %08h want %08h", e.id, e.asel, out_a, e.ea);
                end
                if (out_b !== e.eb) begin
                    mismatched++;
                    $display("FAIL outb txn %0d sel %0d: got %08h want %08h", e.id, e.bsel, out_b, e.eb);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b1; din = '0; fun_sel = '0; reg_sel = '0; scr_sel = '0; a_sel = '0; b_sel = '0;
        op(1'b0, 3'd1, 4'hF, 4'hF, 32'hFFFF_FFFF, 3'd0, 3'd0);
        read_all();

        // Combinational read of preloaded R1/R2 without an enabling edge.
        op(1'b1, 3'd2, 4'b1000, 4'd0, 32'h1234_5678, 3'd0, 3'd1);
        op(1'b1, 3'd2, 4'b0100, 4'd0, 32'h5678_1234, 3'd0, 3'd1);
        rd(3'd0, 3'd1);

        // Selective load.
        load_all(32'h1234_5678);
        op(1'b1, 3'd2, 4'b1010, 4'b0101, 32'h3456_7890, 3'd1, 3'd5);
        rd(3'd1, 3'd5);
        read_all();

        // Increment/decrement wrap on R4.
        op(1'b1, 3'd2, 4'b0001, 4'd0, 32'hFFFF_FFFF, 3'd3, 3'd3);
        op(1'b1, 3'd1, 4'b0001, 4'd0, 32'd0, 3'd3, 3'd3);
        op(1'b1, 3'd0, 4'b0001, 4'd0, 32'd0, 3'd3, 3'd3);
        rd(3'd3, 3'd3);

        // Partial writes on S3.
        op(1'b1, 3'd4, 4'd0, 4'b0010, 32'hAABB_80CC, 3'd6, 3'd6);
        op(1'b1, 3'd5, 4'd0, 4'b0010, 32'hAABB_80CC, 3'd6, 3'd6);
        op(1'b1, 3'd7, 4'd0, 4'b0010, 32'hAABB_80CC, 3'd6, 3'd6);
        op(1'b1, 3'd2, 4'd0, 4'b0010, 32'h1122_3344, 3'd6, 3'd6);
        op(1'b1, 3'd6, 4'd0, 4'b0010, 32'h0000_00EE, 3'd6, 3'd6);
        rd(3'd6, 3'd6);

        // Reset priority over FunSel with enables off.
        load_all(32'hDEAD_BEEF);
        op(1'b0, 3'd1, 4'd0, 4'd0, 32'd0, 3'd2, 3'd7);
        read_all();
        for (int k = 0; k < 4; k++) rd(3'(k + 4), 3'(k));

        // Clear and hold: distinct contents first, then clear R1 and S1 only.
        for (int k = 0; k < 8; k++)
            op(1'b1, 3'd2, (k < 4) ? 4'(8 >> k) : 4'd0, (k >= 4) ? 4'(8 >> (k - 4)) : 4'd0,
               32'hA000_0000 + 32'(k * 32'h0101_0101), 3'(k), 3'(k));
        op(1'b1, 3'd3, 4'b1000, 4'b1000, 32'hFFFF_FFFF, 3'd0, 3'd4);
        read_all();

        // Randomized operations and reads.
        for (int n = 0; n < 300; n++) begin
            op(($urandom_range(0, 19) != 0), 3'($urandom), 4'($urandom), 4'($urandom),
               $urandom, 3'($urandom), 3'($urandom));
        end
        read_all();

        repeat (3) @(negedge clk);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
